// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, dividend} left, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] dividendIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] dividendOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Since remIn < divisor, shifted < 2*divisor, so bit WIDTH of the trial is a true sign bit.
  always_comb begin
    shifted = {remIn, dividendIn[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      remOut      = trial[WIDTH-1:0];
      dividendOut = {dividendIn[WIDTH-2:0], 1'b1};
    end else begin
      remOut      = shifted[WIDTH-1:0];
      dividendOut = {dividendIn[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider for EX: one quotient bit per cycle, result = {rem, quot}.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic               hold,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  divState_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] dvdReg;
  logic [WIDTH-1:0] dsrReg;
  logic             negQuot;
  logic             negRem;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] stepRem;
  logic [WIDTH-1:0] stepQuot;
  logic [WIDTH-1:0] fixQuot;
  logic [WIDTH-1:0] fixRem;

  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn      (remReg),
    .dividendIn (dvdReg),
    .divisor    (dsrReg),
    .remOut     (stepRem),
    .dividendOut(stepQuot)
  );

  // Operand magnitudes at capture and sign fixup of the final step's outputs.
  always_comb begin
    absA    = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
    absB    = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
    fixQuot = negQuot ? (~stepQuot + 1'b1) : stepQuot;
    fixRem  = negRem  ? (~stepRem + 1'b1)  : stepRem;
  end

  // Control FSM with registered ready/result; annul overrides start and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready   <= 1'b0;
      result  <= '0;
      remReg  <= '0;
      dvdReg  <= '0;
      dsrReg  <= '0;
      negQuot <= 1'b0;
      negRem  <= 1'b0;
    end else if (annul) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (opdata2 != '0) begin
              dvdReg  <= absA;
              dsrReg  <= absB;
              remReg  <= '0;
              negQuot <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
              negRem  <= signed_div & opdata1[WIDTH-1];
              cnt     <= '0;
              state   <= BUSY;
            end else begin
              result <= '0;
              ready  <= 1'b1;
              state  <= DONE;
            end
          end
        end
        BUSY: begin
          remReg <= stepRem;
          dvdReg <= stepQuot;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result <= {fixRem, fixQuot};
            ready  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!hold) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a result scoreboard queue.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic        hold;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sbQ[$];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .annul     (annul),
    .hold      (hold),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .result    (result),
    .ready     (ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle number (1 = cycle after the start edge) at which ready is first seen.
  task automatic waitReady(input int limit, output int n);
    n = 1;
    while (ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Present one divide for exactly one edge, then scramble inputs to prove they are latched.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [63:0] exp);
    start      = 1'b1;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    if (push) sbQ.push_back(exp);
    tick();
    start      = 1'b0;
    signed_div = ~sgn;
    opdata1    = $urandom;
    opdata2    = $urandom;
  endtask

  task automatic expectDone(input string tag, input int lat);
    int          n;
    logic [63:0] exp;
    waitReady(40, n);
    check({tag, "_latency"}, 64'(n), 64'(lat));
    if (sbQ.size() == 0) exp = 'x;
    else exp = sbQ.pop_front();
    check({tag, "_result"}, result, exp);
  endtask

  task automatic udiv(input string tag, input logic [31:0] a, input logic [31:0] b);
    launch(1'b0, a, b, 1'b1, {a % b, a / b});
    expectDone(tag, 33);
    tick();
    check({tag, "_drop"}, 64'(ready), 64'(0));
  endtask

  task automatic sdiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp);
    launch(1'b1, a, b, 1'b1, exp);
    expectDone(tag, 33);
    tick();
    check({tag, "_drop"}, 64'(ready), 64'(0));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    hold       = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    tick();
    tick();
    check("reset_ready", 64'(ready), 64'(0));
    check("reset_result", result, 64'h0);
    rst = 1'b0;
    tick();

    udiv("u7div2", 32'd7, 32'd2);

    // Divide by zero: ready one cycle after start, result cleared
    launch(1'b0, 32'd5, 32'd0, 1'b1, 64'h0);
    expectDone("divzero", 1);
    tick();
    check("divzero_drop", 64'(ready), 64'(0));

    sdiv("sneg7div2", 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    sdiv("soverflow", 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    udiv("umaxdiv16", 32'hFFFF_FFFF, 32'h10);
    sdiv("s7divneg2", 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD});
    udiv("uminpos", 32'h8000_0000, 32'hFFFF_FFFF);

    // Annul in BUSY cycle 10: no ready, previous result kept, fresh divide runs in full
    launch(1'b0, 32'd9, 32'd4, 1'b0, 64'h0);
    repeat (9) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check("annul_ready", 64'(ready), 64'(0));
    check("annul_result", result, {32'h8000_0000, 32'h0});
    udiv("after_annul", 32'd100, 32'd7);

    // Hold for three cycles after DONE entry: four ready cycles with stable result
    launch(1'b0, 32'd1000, 32'd3, 1'b1, {32'd1, 32'd333});
    expectDone("hold", 33);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ready", 64'(ready), 64'(1));
      check("hold_result", result, {32'd1, 32'd333});
    end
    hold = 1'b0;
    tick();
    check("hold_release", 64'(ready), 64'(0));

    // Back-to-back with start held high: one bubble cycle, then a full divide
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd50;
    opdata2    = 32'd6;
    sbQ.push_back({32'd2, 32'd8});
    tick();
    opdata1 = 32'h1111_1111;
    opdata2 = 32'h0;
    expectDone("b2b_first", 33);
    opdata1 = 32'hDEAD_BEEF;
    opdata2 = 32'h0000_1234;
    sbQ.push_back({32'hDEAD_BEEF % 32'h0000_1234, 32'hDEAD_BEEF / 32'h0000_1234});
    tick();
    check("b2b_bubble", 64'(ready), 64'(0));
    tick();
    start   = 1'b0;
    opdata1 = $urandom;
    opdata2 = $urandom;
    expectDone("b2b_second", 33);
    tick();

    // Reset mid-BUSY clears result and returns to IDLE
    launch(1'b0, 32'd9, 32'd4, 1'b0, 64'h0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstbusy_ready", 64'(ready), 64'(0));
    check("rstbusy_result", result, 64'h0);
    sdiv("after_rst", 32'hFFFF_FFF7, 32'd4, {32'hFFFF_FFFF, 32'hFFFF_FFFE});

    check("scoreboard_empty", 64'(sbQ.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit signed/unsigned divider in the EX stage. It produces the 64-bit {remainder, quotient} pair written to HI/LO and drives the `divreadyE` input that the hazard unit uses to raise `divstallE`. It computes one restoring-division bit per cycle, holds its result while the pipeline is stalled, and aborts on exception flush.

## Interface
- `WIDTH`, default 32: operand width; result is 2*WIDTH.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  a divide instruction occupies EX (`isdivE`).
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU.
- `annul`  in  1  exception flush; abandons any operation.
- `hold`  in  1  EX stalled by a later stage (`stallM`); keeps a finished result presented.
- `opdata1`  in  WIDTH  dividend (forwarded srcaE).
- `opdata2`  in  WIDTH  divisor (forwarded srcbE).
- `result`  out  2*WIDTH  [2W-1:W] = remainder (HI), [W-1:0] = quotient (LO).
- `ready`  out  1  result valid this cycle (`divreadyE`).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `start & ~annul & opdata2 != 0`: latch |opdata1| and |opdata2| (magnitudes only when `signed_div`). Latch sign flags: quotient negative = sign(op1) XOR sign(op2); remainder negative = sign(op1). Clear the partial remainder, set `cnt` = 0, go to BUSY.
  - `start & ~annul & opdata2 == 0`: `result` <= 0, go to DONE.
  - Otherwise stay in IDLE.
- BUSY: one restoring step per cycle.
  - Shift {rem, dividend} left 1.
  - Trial subtract = rem − divisor, computed at WIDTH+1 bits.
  - If the trial result is non-negative, rem takes the difference and the shifted-in quotient bit is 1; otherwise the bit is 0.
  - `cnt` increments.
  - The step with `cnt` == WIDTH−1 is the last one. On that step, apply sign fixup (two's-complement negate of quotient and/or remainder per the latched flags), register `result`, and go to DONE.
- DONE: `ready` = 1.
  - `hold` = 1: stay in DONE, `result` stable.
  - `hold` = 0: go to IDLE.
  - `start` is ignored in DONE.
- Magnitude arithmetic is unsigned WIDTH bits. |0x80000000| = 0x80000000 is valid.
- `annul` in any state: next state IDLE, `ready` = 0, `result` unchanged. `annul` has priority over `start` and `hold`.
- `rst`: state IDLE, `cnt` = 0, `ready` = 0, `result` = 0.

## Timing
- `ready` is registered and equals (state == DONE).
- Non-zero divisor: `start` is sampled in IDLE at edge 0. BUSY covers cycles 1..WIDTH. `ready` is high in cycle WIDTH+1 (33 for WIDTH=32).
- Zero divisor: `ready` is high in cycle 1.
- `ready` is high for 1 cycle plus the number of cycles `hold` is asserted in DONE.
- Back-to-back divides: the DONE→IDLE edge coincides with the pipeline advancing. The next divide's `start` is sampled in IDLE on the following cycle, so there is one bubble cycle with `ready` = 0 and `divstallE` asserted.
- Operands are sampled only on the IDLE→BUSY edge. Forwarding changes during BUSY have no effect.
- `start` dropping during BUSY (flush by the stall logic) does not abort. Only `annul` aborts.

## Structure
- Shared package `div_pkg`:
  - state enum (IDLE, BUSY, DONE);
  - `DIV_WIDTH` = 32;
  - `DIV_CNT_W` = $clog2(DIV_WIDTH).
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: rem, dividend bits, divisor.
  - Outputs: next rem, next dividend/quotient bits.
  - Instantiated once inside `div_unit`.
- Top holds the FSM, counter, magnitude/sign capture and result fixup.

## Test plan
- Unsigned 7 / 2: `start` = 1, `signed_div` = 0 → `ready` exactly at cycle 33, `result` = {0x00000001, 0x00000003}.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → `result` = {0xFFFFFFFF, 0xFFFFFFFD}.
- Signed overflow 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Unsigned 0xFFFFFFFF / 0x10 → quotient 0x0FFFFFFF, remainder 0xF.
- Divide by zero: opdata2 = 0 → `ready` at cycle 1, `result` = 0.
- `annul` at cycle 10 of BUSY → `ready` stays 0, state returns to IDLE. A new `start` next cycle runs a full 33-cycle divide with the correct result.
- `hold` = 1 for 3 cycles when DONE is entered → `ready` high for 4 cycles with constant `result`, then 0.
- A second divide with `start` high immediately afterwards → exactly one `ready` = 0 IDLE cycle, then BUSY.
- `rst` mid-BUSY → next cycle `ready` = 0, `result` = 0, state IDLE.
